icache_line_fill: RTL

//  Line-fill engine between fetch stage and Sysbus: on a fetch miss, fetches one aligned cache line as a burst read.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_line_fill.sv | 128 ++++++++++++
 2 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache line-fill engine.
// The Sysbus opcode fields are mirrored here so the request tag is a plain constant.
package icache_pkg;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

  localparam int LINE_BYTES_DEFAULT = 64;

  localparam logic [12:0] ICACHE_REQTAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    REQ,
    RESP,
    DONE
  } fill_state_t;

  function automatic int beats_per_line(input int line_bytes, input int bus_width);
    return (line_bytes * 8) / bus_width;
  endfunction

endpackage

// File: rtl/icache_line_fill.sv
// Line-fill engine: on a fetch miss, arbitrates for Sysbus, issues one burst read
// for the aligned line, assembles the beats and hands the line back to fetch.
module icache_line_fill
  import icache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BYTES     = LINE_BYTES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fill_req,
  input  logic [63:0]                 fill_addr,
  input  logic                        fill_flush,
  output logic                        fill_busy,
  output logic                        fill_done,
  output logic [LINE_BYTES*8-1:0]     fill_line,
  output logic [63:0]                 fill_line_addr,
  output logic                        bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
  input  logic                        bus_reqack,
  input  logic                        bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
  output logic                        bus_respack,
  output logic                        icache_busreq,
  input  logic                        icache_busgrant,
  output logic                        icache_busidle
);

  localparam int BEATS  = beats_per_line(LINE_BYTES, BUS_DATA_WIDTH);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);
  localparam logic [BUS_TAG_WIDTH-1:0] REQTAG = BUS_TAG_WIDTH'(ICACHE_REQTAG);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  fill_state_t                state_reg, state_next;
  logic [BEAT_W-1:0]          beat_reg;
  logic                       flushed_reg;
  logic [63:0]                addr_reg;
  logic [BUS_DATA_WIDTH-1:0]  line_reg [BEATS];
  logic                       resp_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      flushed_reg <= 1'b0;
      addr_reg    <= '0;
      for (int i = 0; i < BEATS; i++) line_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (fill_req && !fill_flush) begin
            addr_reg    <= fill_addr & LINE_MASK;
            flushed_reg <= 1'b0;
          end
        end
        REQ: begin
          if (fill_flush) flushed_reg <= 1'b1;
        end
        RESP: begin
          // A flush cannot abort the burst; it only marks the result as stale.
          if (fill_flush) flushed_reg <= 1'b1;
          if (resp_hit) begin
            for (int i = 0; i < BEATS; i++)
              if (beat_reg == BEAT_W'(i)) line_reg[i] <= bus_resp;
            beat_reg <= (beat_reg == LAST_BEAT) ? '0 : beat_reg + 1'b1;
          end
        end
        DONE: beat_reg <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next     = state_reg;
    resp_hit       = 1'b0;
    fill_busy      = (state_reg != IDLE);
    fill_done      = 1'b0;
    bus_reqcyc     = 1'b0;
    bus_req        = '0;
    bus_reqtag     = '0;
    icache_busreq  = 1'b0;
    icache_busidle = 1'b1;
    case (state_reg)
      IDLE: begin
        if (fill_req && !fill_flush) state_next = ARB;
      end
      ARB: begin
        icache_busreq  = 1'b1;
        icache_busidle = 1'b0;
        if (fill_flush)           state_next = IDLE;
        else if (icache_busgrant) state_next = REQ;
      end
      REQ: begin
        icache_busreq  = 1'b1;
        icache_busidle = 1'b0;
        bus_reqcyc     = 1'b1;
        bus_req        = BUS_DATA_WIDTH'(addr_reg);
        bus_reqtag     = REQTAG;
        if (bus_reqack) state_next = RESP;
      end
      RESP: begin
        icache_busreq  = 1'b1;
        icache_busidle = 1'b0;
        resp_hit       = bus_respcyc && (bus_resptag == REQTAG);
        if (resp_hit && beat_reg == LAST_BEAT) state_next = DONE;
      end
      DONE: begin
        fill_done  = !flushed_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus_respack    = resp_hit;
  assign fill_line_addr = addr_reg;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
    assign fill_line[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = line_reg[gi];
  end

endmodule
